// File: rtl/video_pattern_gen.sv
// video_pattern_gen: AXI4-Stream synthetic video source (tuser on frame start, tlast on end of line).
// Patterns x-ramp, y-ramp, x+y and checkerboard; geometry, gap and pattern are latched per frame.
module video_pattern_gen #(
  parameter int TDATA_WIDTH   = 32,
  parameter int PX_WIDTH      = 30,
  parameter int MAX_LINE_SIZE = 1920,
  parameter int MAX_LINES     = 1080,
  parameter int GAP_W         = 8,
  parameter int CHK_BIT       = 3,
  parameter int XW            = $clog2(MAX_LINE_SIZE + 1),
  parameter int YW            = $clog2(MAX_LINES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   cont_i,
  input  logic [1:0]             pattern_i,
  input  logic [XW-1:0]          frame_width_i,
  input  logic [YW-1:0]          frame_height_i,
  input  logic [GAP_W-1:0]       line_gap_i,
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tvalid,
  input  logic                   video_o_tready,
  output logic                   video_o_tlast,
  output logic                   video_o_tuser,
  output logic                   busy_o,
  output logic                   frame_done_o
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;
  state_t                  r_state, w_state_nx;
  logic [XW-1:0]           r_x, w_x_nx, r_w, w_w_nx;
  logic [YW-1:0]           r_y, w_y_nx, r_h, w_h_nx;
  logic [GAP_W-1:0]        r_gap, w_gap_nx, r_gap_cnt, w_gap_cnt_nx;
  logic [1:0]              r_pat, w_pat_nx;
  logic                    r_tvalid, w_valid_nx, r_tlast, r_tuser, r_busy, w_busy_nx;
  logic [TDATA_WIDTH-1:0]  r_tdata;
  logic [PX_WIDTH-1:0]     w_px;
  logic                    w_hs, w_eof, w_geom_ok, w_load;

  assign w_hs      = r_tvalid & video_o_tready;
  assign w_eof     = w_hs & r_tlast & (r_y == r_h - YW'(1));
  assign w_geom_ok = (|frame_width_i) & (|frame_height_i);

  always_comb begin
    w_state_nx   = r_state;
    w_x_nx       = r_x;
    w_y_nx       = r_y;
    w_gap_cnt_nx = r_gap_cnt;
    w_valid_nx   = r_tvalid;
    w_busy_nx    = r_busy;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: if (start_i && w_geom_ok) begin
        w_load     = 1'b1;
        w_state_nx = S_ACTIVE;
        w_x_nx     = '0;
        w_y_nx     = '0;
        w_valid_nx = 1'b1;
        w_busy_nx  = 1'b1;
      end
      S_ACTIVE: if (w_hs) begin
        if (!r_tlast) w_x_nx = r_x + XW'(1);
        else if (w_eof) begin
          w_x_nx = '0;
          w_y_nx = '0;
          // continuous mode restarts with no gap and freshly latched inputs
          if (cont_i && w_geom_ok) w_load = 1'b1;
          else begin
            w_state_nx = S_IDLE;
            w_valid_nx = 1'b0;
            w_busy_nx  = 1'b0;
          end
        end else begin
          w_x_nx = '0;
          w_y_nx = r_y + YW'(1);
          if (r_gap != '0) begin
            w_state_nx   = S_GAP;
            w_gap_cnt_nx = r_gap;
            w_valid_nx   = 1'b0;
          end
        end
      end
      S_GAP: begin
        w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
        if (r_gap_cnt == GAP_W'(1)) begin
          w_state_nx = S_ACTIVE;
          w_valid_nx = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_w_nx   = w_load ? frame_width_i : r_w;
    w_h_nx   = w_load ? frame_height_i : r_h;
    w_gap_nx = w_load ? line_gap_i : r_gap;
    w_pat_nx = w_load ? pattern_i : r_pat;
  end

  // pixel is computed for the coordinate presented next, so data stays put while stalled
  always_comb
    w_px = (w_pat_nx == 2'd0) ? PX_WIDTH'(w_x_nx) :
           (w_pat_nx == 2'd1) ? PX_WIDTH'(w_y_nx) :
           (w_pat_nx == 2'd2) ? PX_WIDTH'(w_x_nx) + PX_WIDTH'(w_y_nx) :
           {PX_WIDTH{w_x_nx[CHK_BIT] ^ w_y_nx[CHK_BIT]}};

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_pat     <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_tdata   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_x       <= w_x_nx;
      r_y       <= w_y_nx;
      r_w       <= w_w_nx;
      r_h       <= w_h_nx;
      r_gap     <= w_gap_nx;
      r_gap_cnt <= w_gap_cnt_nx;
      r_pat     <= w_pat_nx;
      r_tvalid  <= w_valid_nx;
      r_tlast   <= w_valid_nx & (w_x_nx == w_w_nx - XW'(1));
      r_tuser   <= w_valid_nx & (w_x_nx == '0) & (w_y_nx == '0);
      r_tdata   <= w_valid_nx ? TDATA_WIDTH'(w_px) : '0;
      r_busy    <= w_busy_nx;
    end

  assign video_o_tdata  = r_tdata;
  assign video_o_tvalid = r_tvalid;
  assign video_o_tlast  = r_tlast;
  assign video_o_tuser  = r_tuser;
  assign busy_o         = r_busy;
  assign frame_done_o   = w_eof;
endmodule
